// File: rtl/jtag_1149_d10_pkg.sv
// ---------------------------------------------------------------------------
// jtag_1149_d10_pkg
//   Shared definitions for the IEEE1149.10 master error scheduler:
//   - error code values (code i maps to pending bit i-1)
//   - scheduler FSM state type
//   - helper to turn a code into its one-hot pending-bit mask
// ---------------------------------------------------------------------------
package jtag_1149_d10_pkg;

    localparam int unsigned NUM_ERR = 7;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] OPCODE   = 3'd1;
    localparam logic [2:0] EOP2     = 3'd2;
    localparam logic [2:0] EOP3     = 3'd3;
    localparam logic [2:0] UNRECOV  = 3'd4;
    localparam logic [2:0] LPBK     = 3'd5;
    localparam logic [2:0] TIMEOUT  = 3'd6;
    localparam logic [2:0] IDLECNT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } sched_state_t;

    // One-hot pending mask for a code; ERR_NONE maps to an empty mask.
    function automatic logic [NUM_ERR-1:0] code_mask(input logic [2:0] c);
        if (c == ERR_NONE) begin
            return '0;
        end
        return NUM_ERR'(1) << (c - 3'd1);
    endfunction

endpackage

// File: rtl/jtag_1149_d10_err_prio_enc.sv
// ---------------------------------------------------------------------------
// jtag_1149_d10_err_prio_enc
//   Combinational fixed-priority encoder over the pending error set.
//   Priority, highest first: 4, 1, 2, 3, 5, 6, 7.
// Ports:
//   pending   in  7  bit i-1 = code i pending
//   code      out 3  highest-priority pending code (0 when none)
//   clr_mask  out 7  one-hot mask of the selected pending bit
// ---------------------------------------------------------------------------
module jtag_1149_d10_err_prio_enc
    import jtag_1149_d10_pkg::*;
(
    input  logic [NUM_ERR-1:0] pending,
    output logic [2:0]         code,
    output logic [NUM_ERR-1:0] clr_mask
);

    always_comb begin
        code = ERR_NONE;
        if      (pending[UNRECOV - 3'd1]) code = UNRECOV;
        else if (pending[OPCODE  - 3'd1]) code = OPCODE;
        else if (pending[EOP2    - 3'd1]) code = EOP2;
        else if (pending[EOP3    - 3'd1]) code = EOP3;
        else if (pending[LPBK    - 3'd1]) code = LPBK;
        else if (pending[TIMEOUT - 3'd1]) code = TIMEOUT;
        else if (pending[IDLECNT - 3'd1]) code = IDLECNT;
        clr_mask = code_mask(code);
    end

endmodule

// File: rtl/jtag_1149_d10_mstr_err_sched.sv
// ---------------------------------------------------------------------------
// jtag_1149_d10_mstr_err_sched
//   Master-side error event scheduler. Edge-detects the seven master error
//   conditions, queues them as pending codes 1..7 and presents them one at a
//   time in priority order over a valid/ack handshake.
// Parameters:
//   HOLD_CYCLES  idle cycles after each ack before the next code (0 = none)
//   CNT_W        width of the saturating merge counter
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sched_en              present pending codes when 1
//   clr                   synchronous flush of pending, counter, last_code, FSM
//   opcode_error .. idle_count_error   error condition levels
//   status_ack            consumer accepts status_code
//   status_valid/_code    presented code, held until acked
//   last_code             last acked code
//   err_pending           bit i-1 = code i pending
//   merge_cnt             events merged into already-pending codes (saturating)
//   busy                  FSM not in IDLE
// ---------------------------------------------------------------------------
module jtag_1149_d10_mstr_err_sched
    import jtag_1149_d10_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sched_en,
    input  logic               clr,
    input  logic               opcode_error,
    input  logic [1:0]         eop_error,
    input  logic               unrecoverable_error,
    input  logic               lpbk_error,
    input  logic               scan_rsp_time_out,
    input  logic               idle_count_error,
    input  logic               status_ack,
    output logic               status_valid,
    output logic [2:0]         status_code,
    output logic [2:0]         last_code,
    output logic [NUM_ERR-1:0] err_pending,
    output logic [CNT_W-1:0]   merge_cnt,
    output logic               busy
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    sched_state_t        state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NUM_ERR-1:0]  cond, cond_q, ev;
    logic [NUM_ERR-1:0]  sel_mask, clear_mask, merges, pending_d;
    logic [2:0]          sel_code;
    logic [2:0]          merge_pop;
    logic [CNT_W:0]      merge_sum;
    logic [CNT_W-1:0]    merge_cnt_d;
    logic                take, ack_fire;

    // Decoded condition levels; each eop code decodes from the full 2-bit
    // value so 10 -> 11 is a fresh edge for code 3.
    always_comb begin
        cond = {idle_count_error,
                scan_rsp_time_out,
                lpbk_error,
                unrecoverable_error,
                (eop_error == 2'b11),
                (eop_error == 2'b10),
                opcode_error};
        ev = cond & ~cond_q;
    end

    jtag_1149_d10_err_prio_enc u_prio_enc (
        .pending  (err_pending),
        .code     (sel_code),
        .clr_mask (sel_mask)
    );

    // FSM next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        take       = 1'b0;
        ack_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sched_en && (err_pending != '0)) begin
                    take    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (status_ack) begin
                    ack_fire   = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = (HOLD_CYCLES > 0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            take       = 1'b0;
            ack_fire   = 1'b0;
        end
    end

    // Pending update: the set from ev is ORed in after the selection clear,
    // so a same-cycle event on the selected bit keeps it pending (and is not
    // counted as a merge).
    always_comb begin
        clear_mask = take ? sel_mask : '0;
        pending_d  = (err_pending & ~clear_mask) | ev;
        merges     = ev & err_pending & ~clear_mask;
        merge_pop  = '0;
        for (int unsigned i = 0; i < NUM_ERR; i++) begin
            merge_pop = merge_pop + {2'b00, merges[i]};
        end
        merge_sum   = {1'b0, merge_cnt} + (CNT_W+1)'(merge_pop);
        merge_cnt_d = merge_sum[CNT_W] ? '1 : merge_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q       <= '0;
            err_pending  <= '0;
            merge_cnt    <= '0;
            status_valid <= 1'b0;
            status_code  <= ERR_NONE;
            last_code    <= ERR_NONE;
        end else begin
            // History tracks the inputs even during clr, so events in the
            // clr cycle are consumed rather than replayed afterwards.
            cond_q <= cond;
            if (clr) begin
                err_pending  <= '0;
                merge_cnt    <= '0;
                status_valid <= 1'b0;
                status_code  <= ERR_NONE;
                last_code    <= ERR_NONE;
            end else begin
                err_pending <= pending_d;
                merge_cnt   <= merge_cnt_d;
                if (take) begin
                    status_code  <= sel_code;
                    status_valid <= 1'b1;
                end
                if (ack_fire) begin
                    status_valid <= 1'b0;
                    last_code    <= status_code;
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_jtag_1149_d10_mstr_err_sched.sv
// ---------------------------------------------------------------------------
// tb_jtag_1149_d10_mstr_err_sched
//   Scoreboard bench: a behavioural reference model queues each code it
//   expects to be presented; a monitor pops and compares at every accepted
//   handshake, and a per-cycle checker compares the status outputs.
// ---------------------------------------------------------------------------
module tb_jtag_1149_d10_mstr_err_sched;

    localparam int HOLD = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sched_en, clr, opcode_error;
    logic [1:0] eop_error;
    logic       unrecoverable_error, lpbk_error, scan_rsp_time_out, idle_count_error;
    logic       status_ack;
    logic       status_valid;
    logic [2:0] status_code, last_code;
    logic [6:0] err_pending;
    logic [CW-1:0] merge_cnt;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    jtag_1149_d10_mstr_err_sched #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sched_en            (sched_en),
        .clr                 (clr),
        .opcode_error        (opcode_error),
        .eop_error           (eop_error),
        .unrecoverable_error (unrecoverable_error),
        .lpbk_error          (lpbk_error),
        .scan_rsp_time_out   (scan_rsp_time_out),
        .idle_count_error    (idle_count_error),
        .status_ack          (status_ack),
        .status_valid        (status_valid),
        .status_code         (status_code),
        .last_code           (last_code),
        .err_pending         (err_pending),
        .merge_cnt           (merge_cnt),
        .busy                (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  prio [7] = '{4, 1, 2, 3, 5, 6, 7};
    bit  m_hist [1:7];
    bit  m_pend [1:7];
    int  m_merge, m_last, m_code, m_hold_left;
    bit  m_present;
    int  exp_q [$];

    function automatic bit cond_of(input int c);
        case (c)
            1: return opcode_error;
            2: return eop_error == 2'b10;
            3: return eop_error == 2'b11;
            4: return unrecoverable_error;
            5: return lpbk_error;
            6: return scan_rsp_time_out;
            default: return idle_count_error;
        endcase
    endfunction

    function automatic logic [6:0] m_pend_vec();
        logic [6:0] v;
        for (int c = 1; c <= 7; c++) v[c-1] = m_pend[c];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin : ref_model
        bit ev [1:7];
        int pick;
        if (!rst_n) begin
            for (int c = 1; c <= 7; c++) begin
                m_hist[c] = 1'b0;
                m_pend[c] = 1'b0;
            end
            m_merge = 0; m_last = 0; m_code = 0; m_present = 0; m_hold_left = 0;
            exp_q.delete();
        end else begin
            for (int c = 1; c <= 7; c++) begin
                ev[c]     = cond_of(c) && !m_hist[c];
                m_hist[c] = cond_of(c);
            end
            if (clr) begin
                for (int c = 1; c <= 7; c++) m_pend[c] = 1'b0;
                m_merge = 0; m_last = 0; m_code = 0; m_present = 0; m_hold_left = 0;
                exp_q.delete();
            end else begin
                pick = 0;
                if (m_present) begin
                    if (status_ack) begin
                        m_last      = m_code;
                        m_present   = 0;
                        m_hold_left = HOLD;
                    end
                end else if (m_hold_left > 0) begin
                    m_hold_left--;
                end else if (sched_en) begin
                    foreach (prio[k]) if (pick == 0 && m_pend[prio[k]]) pick = prio[k];
                end
                if (pick != 0) m_pend[pick] = 1'b0;
                for (int c = 1; c <= 7; c++) begin
                    if (ev[c]) begin
                        if (m_pend[c]) m_merge = (m_merge < CMAX) ? m_merge + 1 : CMAX;
                        m_pend[c] = 1'b1;
                    end
                end
                if (pick != 0) begin
                    m_present = 1;
                    m_code    = pick;
                    exp_q.push_back(pick);
                end
            end
        end
    end

    // ---------------- monitor: pop at each accepted handshake ----------------
    always @(posedge clk) begin
        if (rst_n && !clr && status_valid && status_ack) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_code", status_code, 0);
            end else begin
                chk("sb_code", status_code, exp_q.pop_front());
            end
        end
    end

    // ---------------- per-cycle output check ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid",   status_valid, m_present);
            chk("code",    status_code,  m_code);
            chk("last",    last_code,    m_last);
            chk("pending", err_pending,  m_pend_vec());
            chk("merge",   merge_cnt,    m_merge);
            chk("busy",    busy,         (m_present || m_hold_left > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic errs_low();
        opcode_error = 0; eop_error = 2'b00; unrecoverable_error = 0;
        lpbk_error = 0; scan_rsp_time_out = 0; idle_count_error = 0;
    endtask

    task automatic wait_valid(input int maxc);
        int k;
        k = 0;
        while (!status_valid && k < maxc) begin
            step();
            k++;
        end
        chk("wait_valid", status_valid, 1);
    endtask

    task automatic drain(input int n);
        sched_en = 1; status_ack = 1; errs_low();
        repeat (n) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise [4];
        int codes [4];
        int n_rise, busy_fall, n_one;
        bit prev_v;

        rst_n = 0; sched_en = 0; clr = 0; status_ack = 0;
        errs_low();
        repeat (3) step();
        chk("rst_valid",   status_valid, 0);
        chk("rst_code",    status_code,  0);
        chk("rst_last",    last_code,    0);
        chk("rst_pending", err_pending,  0);
        chk("rst_merge",   merge_cnt,    0);
        chk("rst_busy",    busy,         0);
        rst_n = 1;
        step();

        // 1: single opcode pulse, ack held high
        sched_en = 1; status_ack = 1;
        opcode_error = 1; step();
        opcode_error = 0; step();
        chk("t1_valid_lat2", status_valid, 1);
        chk("t1_code",       status_code,  1);
        step();
        chk("t1_valid_off",  status_valid, 0);
        chk("t1_last",       last_code,    1);
        chk("t1_pending",    err_pending,  0);
        repeat (4) step();

        // 2: simultaneous 4,5,7 serialised with HOLD gaps
        unrecoverable_error = 1; lpbk_error = 1; idle_count_error = 1;
        n_rise = 0; busy_fall = -1; prev_v = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (status_valid && !prev_v && n_rise < 4) begin
                rise[n_rise]  = cyc;
                codes[n_rise] = status_code;
                n_rise++;
            end
            prev_v = status_valid;
            if (n_rise == 3 && !busy && busy_fall < 0) busy_fall = cyc;
        end
        chk("t2_nrise", n_rise, 3);
        if (n_rise == 3) begin
            chk("t2_code0", codes[0], 4);
            chk("t2_code1", codes[1], 5);
            chk("t2_code2", codes[2], 7);
            chk("t2_gap01", rise[1] - rise[0], HOLD + 2);
            chk("t2_gap12", rise[2] - rise[1], HOLD + 2);
            chk("t2_busy_fall", busy_fall - rise[2], HOLD + 1);
        end
        errs_low();
        step();

        // 3: long level -> one event; then two pulses while pending -> one merge
        n_one = 0; prev_v = status_valid;
        opcode_error = 1;
        for (int k = 0; k < 16; k++) begin
            if (k == 10) opcode_error = 0;
            step();
            if (status_valid && !prev_v) n_one++;
            prev_v = status_valid;
        end
        chk("t3_one_event", n_one, 1);
        chk("t3_merge0",    merge_cnt, 0);
        sched_en = 0;
        opcode_error = 1; step(); opcode_error = 0; step();
        opcode_error = 1; step(); opcode_error = 0; step();
        chk("t3_pending", err_pending, 7'b0000001);
        chk("t3_merge1",  merge_cnt, 1);
        drain(10);

        // 4: eop decode 00->10->11 and 00->01
        sched_en = 0;
        eop_error = 2'b10; step();
        eop_error = 2'b11; step();
        eop_error = 2'b00; step(); step();
        chk("t4_pend23", err_pending, 7'b0000110);
        drain(14);
        chk("t4_last3", last_code, 3);
        sched_en = 0;
        eop_error = 2'b01; step();
        eop_error = 2'b00; step(); step();
        chk("t4_pend01", err_pending, 0);

        // 5: clr mid-PRESENT with 3 codes still pending
        sched_en = 1; status_ack = 0;
        opcode_error = 1; lpbk_error = 1; scan_rsp_time_out = 1; idle_count_error = 1;
        step();
        wait_valid(10);
        chk("t5_code1", status_code, 1);
        chk("t5_pend3", err_pending, 7'b1110000);
        clr = 1; step(); clr = 0;
        chk("t5_valid", status_valid, 0);
        chk("t5_pend",  err_pending,  0);
        chk("t5_merge", merge_cnt,    0);
        chk("t5_busy",  busy,         0);
        status_ack = 1; sched_en = 0;
        repeat (3) step();
        chk("t5_ack_ignored_valid", status_valid, 0);
        chk("t5_ack_ignored_last",  last_code,    0);
        errs_low(); step();

        // 6: merge saturation, then async reset mid-PRESENT
        sched_en = 0; status_ack = 0;
        for (int k = 0; k < 45; k++) begin
            opcode_error = 1; eop_error = 2'b11; unrecoverable_error = 1;
            lpbk_error = 1; scan_rsp_time_out = 1; idle_count_error = 1;
            step();
            errs_low();
            step();
        end
        chk("t6_sat", merge_cnt, CMAX);
        sched_en = 1;
        wait_valid(10);
        chk("t6_present_code", status_code, 4);
        #2 rst_n = 0;
        #1;
        chk("t6_arst_valid",   status_valid, 0);
        chk("t6_arst_code",    status_code,  0);
        chk("t6_arst_last",    last_code,    0);
        chk("t6_arst_pending", err_pending,  0);
        chk("t6_arst_merge",   merge_cnt,    0);
        chk("t6_arst_busy",    busy,         0);
        step(); step();
        rst_n = 1;
        step();

        // random phase: model and scoreboard do the checking
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7) == 0) opcode_error        = ~opcode_error;
            if ($urandom_range(5) == 0) eop_error           = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) unrecoverable_error = ~unrecoverable_error;
            if ($urandom_range(7) == 0) lpbk_error          = ~lpbk_error;
            if ($urandom_range(7) == 0) scan_rsp_time_out   = ~scan_rsp_time_out;
            if ($urandom_range(7) == 0) idle_count_error    = ~idle_count_error;
            status_ack = 1'($urandom_range(1));
            sched_en   = ($urandom_range(9) != 0);
            clr        = ($urandom_range(49) == 0);
            step();
        end
        clr = 0;
        drain(60);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_pending",     err_pending,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
